// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC and the instruction RAM read path, and sequences BOOT/RUN/HALT.
// Optional FETCH_RETIRE_COUNT_EN adds a counter of issued instructions.
module fetch_unit #(
    parameter logic [15:0] PC_RESET = 16'h0000,
    parameter logic [15:0] NOP_WORD = 16'h0000,
    parameter logic [15:0] STP_WORD = 16'hF800
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        resume,
    input  logic        cnt_en,
    input  logic        pc_sload,
    input  logic [15:0] new_pc,
    input  logic [15:0] instr_out1,
    input  logic [15:0] instr_out2,
    output logic [15:0] pc,
    output logic [15:0] instr,
    output logic [15:0] N,
`ifdef FETCH_RETIRE_COUNT_EN
    output logic [15:0] retire_count,
`endif
    output logic        issue_valid,
    output logic        halted
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] hold_instr_q, hold_instr_d;
    logic [15:0] hold_n_q, hold_n_d;
    logic        stall_q;
    logic [15:0] pc_dec;

    // PC as the decoder requests it; sload beats increment
    always_comb begin
        pc_dec = pc_q;
        if (pc_sload) begin
            pc_dec = new_pc;
        end else if (cnt_en) begin
            pc_dec = pc_q + 16'd1;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        hold_instr_d = hold_instr_q;
        hold_n_d     = hold_n_q;
        instr        = NOP_WORD;
        N            = 16'h0000;
        issue_valid  = 1'b0;
        halted       = 1'b0;
        unique case (state_q)
            BOOT: begin
                if (!stall) begin
                    pc_d    = pc_dec;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (stall) begin
                    if (!stall_q) begin
                        hold_instr_d = instr_out1;
                        hold_n_d     = instr_out2;
                        instr        = instr_out1;
                        N            = instr_out2;
                    end else begin
                        instr = hold_instr_q;
                        N     = hold_n_q;
                    end
                end else begin
                    instr       = instr_out1;
                    N           = instr_out2;
                    issue_valid = 1'b1;
                    pc_d        = pc_dec;
                    if (instr_out1[15:11] == 5'b11111) begin
                        state_d = HALT;
                    end
                end
            end
            HALT: begin
                instr  = STP_WORD;
                halted = 1'b1;
                if (resume) begin
                    state_d = BOOT;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= BOOT;
            pc_q         <= PC_RESET;
            hold_instr_q <= 16'h0000;
            hold_n_q     <= 16'h0000;
            stall_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            hold_instr_q <= hold_instr_d;
            hold_n_q     <= hold_n_d;
            stall_q      <= stall;
        end
    end

    assign pc = pc_q;

`ifdef FETCH_RETIRE_COUNT_EN
    logic [15:0] retire_q, retire_d;

    always_comb begin
        retire_d = retire_q;
        if (issue_valid) begin
            retire_d = retire_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retire_q <= 16'h0000;
        end else begin
            retire_q <= retire_d;
        end
    end

    assign retire_count = retire_q;
`endif

endmodule
